// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// uart_tx_cfg : FIFO-buffered UART transmitter, configurable width/parity/stop
// Revision    : 1.0
// ============================================================================
module uart_tx_cfg #(
    parameter int DATA_W     = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              tx_send,
    input  logic [DATA_W-1:0]                 data_in,
    input  logic                              baud_en_tx,
    output logic                              tx_ready,
    output logic                              tx_data_out,
    output logic                              tx_active,
    output logic                              tx_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              overflow
);

    localparam int                LVL_W     = $clog2(FIFO_DEPTH + 1);
    localparam int                PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                IDX_W     = $clog2(DATA_W);
    localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_W - 1);
    localparam logic              STOP_LAST = (STOP_BITS == 2);
    localparam logic              ODD_PAR   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_d;
    logic              ready_q;
    logic              overflow_q;

    state_t            state_q;
    logic [DATA_W-1:0] shift_q;
    logic [IDX_W-1:0]  idx_q;
    logic              stop_cnt_q;
    logic              par_q;
    logic              line_q;
    logic              active_q;
    logic              done_q;

    logic              push;
    logic              pop;
    logic              stop_last;
    logic [DATA_W-1:0] head;

    // Ready comes from the registered level, so a full FIFO rejects a push even
    // when the transmitter pops in the same cycle.
    assign push      = tx_send & ready_q;
    assign stop_last = (stop_cnt_q == STOP_LAST);
    assign pop       = baud_en_tx & (level_q != '0) &
                       ((state_q == S_IDLE) | ((state_q == S_STOP) & stop_last));
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ready_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
            ready_q <= (level_d != FULL_LVL);
            if (tx_send && !ready_q) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            line_q     <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (baud_en_tx) begin
                case (state_q)
                    S_IDLE: begin
                        if (pop) begin
                            state_q  <= S_START;
                            shift_q  <= head;
                            par_q    <= (^head) ^ ODD_PAR;
                            line_q   <= 1'b0;
                            active_q <= 1'b1;
                        end
                    end
                    S_START: begin
                        state_q <= S_DATA;
                        idx_q   <= '0;
                        line_q  <= shift_q[0];
                    end
                    S_DATA: begin
                        if (idx_q == LAST_IDX) begin
                            if (PARITY != 0) begin
                                state_q <= S_PAR;
                                line_q  <= par_q;
                            end else begin
                                state_q    <= S_STOP;
                                stop_cnt_q <= 1'b0;
                                line_q     <= 1'b1;
                            end
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            shift_q <= shift_q >> 1;
                            line_q  <= shift_q[1];
                        end
                    end
                    S_PAR: begin
                        state_q    <= S_STOP;
                        stop_cnt_q <= 1'b0;
                        line_q     <= 1'b1;
                    end
                    S_STOP: begin
                        if (stop_last) begin
                            done_q <= 1'b1;
                            // Back-to-back frames: next start bit follows the stop bit directly.
                            if (pop) begin
                                state_q  <= S_START;
                                shift_q  <= head;
                                par_q    <= (^head) ^ ODD_PAR;
                                line_q   <= 1'b0;
                            end else begin
                                state_q  <= S_IDLE;
                                line_q   <= 1'b1;
                                active_q <= 1'b0;
                            end
                        end else begin
                            stop_cnt_q <= stop_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q  <= S_IDLE;
                        line_q   <= 1'b1;
                        active_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_ready    = ready_q;
    assign tx_data_out = line_q;
    assign tx_active   = active_q;
    assign tx_done     = done_q;
    assign fifo_level  = level_q;
    assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_cfg : self-checking bench, three parameterisations of uart_tx_cfg
// Revision       : 1.0
// ============================================================================
module tb_uart_tx_cfg;

    localparam int BAUD_GAP = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       tb_send;
    logic [8:0] tb_data;
    int         sel;

    logic [2:0] send_v, rdy_v, line_v, act_v, done_v, ovf_v;
    logic [2:0] lvl0, lvl1, lvl2;
    logic       obs_line, obs_act, obs_done, obs_rdy, obs_ovf;
    logic [2:0] obs_lvl;

    int cfg_dw   [3] = '{8, 8, 7};
    int cfg_par  [3] = '{2, 1, 0};
    int cfg_stop [3] = '{1, 1, 2};

    int n_cmp  = 0;
    int n_fail = 0;
    int done_cnt = 0;

    logic exp_line [$];
    logic exp_act  [$];

    always #5 clk = ~clk;

    assign send_v[0] = tb_send && (sel == 0);
    assign send_v[1] = tb_send && (sel == 1);
    assign send_v[2] = tb_send && (sel == 2);

    uart_tx_cfg #(.DATA_W(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_even (
        .clk(clk), .rst_n(rst_n), .tx_send(send_v[0]), .data_in(tb_data[7:0]),
        .baud_en_tx(tick), .tx_ready(rdy_v[0]), .tx_data_out(line_v[0]),
        .tx_active(act_v[0]), .tx_done(done_v[0]), .fifo_level(lvl0), .overflow(ovf_v[0]));

    uart_tx_cfg #(.DATA_W(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_odd (
        .clk(clk), .rst_n(rst_n), .tx_send(send_v[1]), .data_in(tb_data[7:0]),
        .baud_en_tx(tick), .tx_ready(rdy_v[1]), .tx_data_out(line_v[1]),
        .tx_active(act_v[1]), .tx_done(done_v[1]), .fifo_level(lvl1), .overflow(ovf_v[1]));

    uart_tx_cfg #(.DATA_W(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_d7s2 (
        .clk(clk), .rst_n(rst_n), .tx_send(send_v[2]), .data_in(tb_data[6:0]),
        .baud_en_tx(tick), .tx_ready(rdy_v[2]), .tx_data_out(line_v[2]),
        .tx_active(act_v[2]), .tx_done(done_v[2]), .fifo_level(lvl2), .overflow(ovf_v[2]));

    always_comb begin
        obs_line = line_v[0]; obs_act = act_v[0]; obs_done = done_v[0];
        obs_rdy  = rdy_v[0];  obs_ovf = ovf_v[0]; obs_lvl  = lvl0;
        case (sel)
            1: begin
                obs_line = line_v[1]; obs_act = act_v[1]; obs_done = done_v[1];
                obs_rdy  = rdy_v[1];  obs_ovf = ovf_v[1]; obs_lvl  = lvl1;
            end
            2: begin
                obs_line = line_v[2]; obs_act = act_v[2]; obs_done = done_v[2];
                obs_rdy  = rdy_v[2];  obs_ovf = ovf_v[2]; obs_lvl  = lvl2;
            end
            default: ;
        endcase
    end

    always @(posedge clk) begin
        if (obs_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tb_send = 1'b0;
        tick    = 1'b0;
        rst_n   = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        exp_line.delete();
        exp_act.delete();
    endtask

    task automatic push_word(input logic [8:0] w);
        tb_data = w;
        tb_send = 1'b1;
        step();
        tb_send = 1'b0;
    endtask

    // Serial frame from first principles: start, LSB-first data, parity, stop bits.
    task automatic model_frame(input logic [8:0] w);
        logic p;
        p = 1'b0;
        exp_line.push_back(1'b0); exp_act.push_back(1'b1);
        for (int b = 0; b < cfg_dw[sel]; b++) begin
            exp_line.push_back(w[b]); exp_act.push_back(1'b1);
            p = p ^ w[b];
        end
        if (cfg_par[sel] != 0) begin
            exp_line.push_back((cfg_par[sel] == 2) ? p : ~p); exp_act.push_back(1'b1);
        end
        for (int s = 0; s < cfg_stop[sel]; s++) begin
            exp_line.push_back(1'b1); exp_act.push_back(1'b1);
        end
    endtask

    task automatic model_idle(input int n);
        for (int i = 0; i < n; i++) begin
            exp_line.push_back(1'b1); exp_act.push_back(1'b0);
        end
    endtask

    task automatic check_stream(input string name);
        int   k;
        logic el, ea;
        k = 0;
        while (exp_line.size() > 0) begin
            el = exp_line.pop_front();
            ea = exp_act.pop_front();
            tick = 1'b1;
            step();
            tick = 1'b0;
            n_cmp++;
            if (obs_line !== el) begin
                n_fail++;
                $display("FAIL %s line bit%0d: got %b want %b", name, k, obs_line, el);
            end
            n_cmp++;
            if (obs_act !== ea) begin
                n_fail++;
                $display("FAIL %s active bit%0d: got %b want %b", name, k, obs_act, ea);
            end
            repeat (BAUD_GAP) step();
            k++;
        end
    endtask

    task automatic test_reset();
        tb_send = 1'b0; tick = 1'b0; tb_data = '0; sel = 0;
        rst_n = 1'b0;
        step();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            n_cmp++;
            if ({obs_line, obs_act, obs_done, obs_rdy, obs_ovf, obs_lvl} !== 8'b1_0_0_1_0_000) begin
                n_fail++;
                $display("FAIL reset inst%0d: got line/act/done/rdy/ovf/lvl %b%b%b%b%b/%0d want 10010/0",
                         s, obs_line, obs_act, obs_done, obs_rdy, obs_ovf, obs_lvl);
            end
        end
        sel = 0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single(input int s, input logic [8:0] w, input string name);
        int base;
        sel = s;
        do_reset();
        push_word(w);
        n_cmp++;
        if (obs_lvl !== 3'd1) begin
            n_fail++;
            $display("FAIL %s level: got %0d want 1", name, obs_lvl);
        end
        base = done_cnt;
        model_frame(w);
        model_idle(2);
        check_stream(name);
        n_cmp++;
        if (done_cnt - base !== 1) begin
            n_fail++;
            $display("FAIL %s done pulses: got %0d want 1", name, done_cnt - base);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        sel = 0;
        do_reset();
        push_word(9'h011);
        push_word(9'h022);
        n_cmp++;
        if (obs_lvl !== 3'd2) begin
            n_fail++;
            $display("FAIL b2b level: got %0d want 2", obs_lvl);
        end
        base = done_cnt;
        model_frame(9'h011);
        model_frame(9'h022);
        model_idle(2);
        check_stream("b2b");
        n_cmp++;
        if (done_cnt - base !== 2) begin
            n_fail++;
            $display("FAIL b2b done pulses: got %0d want 2", done_cnt - base);
        end
    endtask

    task automatic test_push_pop_same_cycle();
        sel = 1;
        do_reset();
        push_word(9'h0C3);
        tb_data = 9'h05A; tb_send = 1'b1; tick = 1'b1;
        step();
        tb_send = 1'b0; tick = 1'b0;
        n_cmp++;
        if (obs_lvl !== 3'd1 || obs_line !== 1'b0) begin
            n_fail++;
            $display("FAIL pushpop level/line: got %0d/%b want 1/0", obs_lvl, obs_line);
        end
        repeat (BAUD_GAP) step();
        model_frame(9'h0C3);
        model_frame(9'h05A);
        model_idle(1);
        void'(exp_line.pop_front());
        void'(exp_act.pop_front());
        check_stream("pushpop");
    endtask

    task automatic test_push_on_idle_tick();
        sel = 2;
        do_reset();
        tb_data = 9'h02B; tb_send = 1'b1; tick = 1'b1;
        step();
        tb_send = 1'b0; tick = 1'b0;
        n_cmp++;
        if (obs_line !== 1'b1 || obs_act !== 1'b0 || obs_lvl !== 3'd1) begin
            n_fail++;
            $display("FAIL idletick line/act/lvl: got %b/%b/%0d want 1/0/1", obs_line, obs_act, obs_lvl);
        end
        repeat (BAUD_GAP) step();
        model_frame(9'h02B);
        model_idle(1);
        check_stream("idletick");
    endtask

    task automatic test_overflow();
        int base;
        logic [8:0] w [5];
        sel = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            w[i] = 9'($urandom_range(0, 255));
            push_word(w[i]);
        end
        n_cmp++;
        if (obs_lvl !== 3'd4 || obs_rdy !== 1'b0 || obs_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf full lvl/rdy/ovf: got %0d/%b/%b want 4/0/1", obs_lvl, obs_rdy, obs_ovf);
        end
        base = done_cnt;
        tb_data = 9'h1FF; tb_send = 1'b1; tick = 1'b1;
        step();
        tb_send = 1'b0; tick = 1'b0;
        n_cmp++;
        if (obs_lvl !== 3'd3 || obs_rdy !== 1'b1 || obs_line !== 1'b0 || obs_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf pop-while-full lvl/rdy/line/ovf: got %0d/%b/%b/%b want 3/1/0/1",
                     obs_lvl, obs_rdy, obs_line, obs_ovf);
        end
        repeat (BAUD_GAP) step();
        for (int i = 0; i < 4; i++) model_frame(w[i]);
        model_idle(3);
        void'(exp_line.pop_front());
        void'(exp_act.pop_front());
        check_stream("ovf");
        n_cmp++;
        if (done_cnt - base !== 4 || obs_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf frames/sticky: got %0d/%b want 4/1", done_cnt - base, obs_ovf);
        end
    endtask

    task automatic test_midframe_reset();
        int base;
        sel = 0;
        do_reset();
        push_word(9'h052);
        push_word(9'h0A7);
        base = done_cnt;
        for (int i = 0; i < 5; i++) begin
            tick = 1'b1; step(); tick = 1'b0;
            repeat (BAUD_GAP) step();
        end
        n_cmp++;
        if (obs_line !== 1'b0 || obs_act !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst bit3 line/act: got %b/%b want 0/1", obs_line, obs_act);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs_line !== 1'b1 || obs_act !== 1'b0 || obs_lvl !== 3'd0 || obs_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst async line/act/lvl/rdy: got %b/%b/%0d/%b want 1/0/0/1",
                     obs_line, obs_act, obs_lvl, obs_rdy);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        model_idle(4);
        check_stream("midrst-idle");
        n_cmp++;
        if (done_cnt - base !== 0) begin
            n_fail++;
            $display("FAIL midrst done pulses: got %0d want 0", done_cnt - base);
        end
        push_word(9'h0E1);
        model_frame(9'h0E1);
        model_idle(1);
        check_stream("midrst-after");
    endtask

    task automatic test_random();
        int n, base;
        logic [8:0] w;
        for (int it = 0; it < 9; it++) begin
            sel = it % 3;
            do_reset();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                w = 9'($urandom & ((1 << cfg_dw[sel]) - 1));
                push_word(w);
                model_frame(w);
            end
            n_cmp++;
            if (obs_lvl !== 3'(n)) begin
                n_fail++;
                $display("FAIL rand%0d level: got %0d want %0d", it, obs_lvl, n);
            end
            base = done_cnt;
            model_idle(2);
            check_stream($sformatf("rand%0d", it));
            n_cmp++;
            if (done_cnt - base !== n) begin
                n_fail++;
                $display("FAIL rand%0d done pulses: got %0d want %0d", it, done_cnt - base, n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single(0, 9'h0AA, "even_AA");
        test_single(1, 9'h0F0, "odd_F0");
        test_single(2, 9'h055, "d7s2_55");
        test_back_to_back();
        test_push_pop_same_cycle();
        test_push_on_idle_tick();
        test_overflow();
        test_midframe_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter PARITY, default 0, parity mode (0 none, 1 odd, 2 even).
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame (legal 1 or 2).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO depth (power of 2, >=2).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port tx_send  input  1  push strobe; writes data_in to FIFO when tx_ready=1.
REQ-008 SHALL have port data_in  input  DATA_W  word to transmit.
REQ-009 SHALL have port baud_en_tx  input  1  bit-rate tick, one clk wide, once per bit period.
REQ-010 SHALL have port tx_ready  output  1  FIFO not full.
REQ-011 SHALL have port tx_data_out  output  1  serial line, idle high.
REQ-012 SHALL have port tx_active  output  1  frame in progress.
REQ-013 SHALL have port tx_done  output  1  one-clk pulse at end of each frame.
REQ-014 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH+1)  words held in FIFO.
REQ-015 SHALL have port overflow  output  1  sticky: push attempted while full.

Function
REQ-016 SHALL accept a push on any clk with tx_send=1 and tx_ready=1; fifo_level +1 next cycle.
REQ-017 SHALL drop a push with tx_send=1 and tx_ready=0 and set overflow=1 (held until reset).
REQ-018 SHALL evaluate tx_ready from registered level only; push while full is rejected even if a pop occurs the same cycle.
REQ-019 SHALL, on simultaneous accepted push and pop, leave fifo_level unchanged.
REQ-020 SHALL implement FSM states IDLE, START, DATA, PAR, STOP; transitions occur only on cycles with baud_en_tx=1.
REQ-021 IDLE: tx_data_out=1, tx_active=0; on tick with FIFO non-empty -> START, pop head word into shift register.
REQ-022 START: tx_data_out=0; on tick -> DATA, bit index 0.
REQ-023 DATA: tx_data_out=current bit, LSB first; after DATA_W ticks -> PAR if PARITY!=0, else STOP.
REQ-024 PAR: tx_data_out = XOR of data bits (even) or its inverse (odd); on tick -> STOP.
REQ-025 STOP: tx_data_out=1; after STOP_BITS ticks frame ends, tx_done=1 for that one clk.
REQ-026 SHALL at frame end go directly to START with a pop if FIFO non-empty (no idle bit), else IDLE.
REQ-027 SHALL, when a push into an empty FIFO coincides with an IDLE tick, not start; frame starts on next tick.
REQ-028 SHALL hold tx_active=1 in START, DATA, PAR, STOP; all outputs registered, change one clk after the causing edge.
REQ-029 SHALL ignore baud_en_tx for pushes; FIFO push/pop pointers wrap modulo FIFO_DEPTH.

Reset
REQ-030 SHALL on rst_n=0 immediately force: FSM IDLE, tx_data_out=1, tx_active=0, tx_done=0, fifo_level=0, tx_ready=1, overflow=0, FIFO contents discarded.
REQ-031 SHALL, on reset mid-frame, abandon the frame; after release, first frame starts only on a tick after a new push.

Verification
REQ-032 Defaults, PARITY=2, push 0xAA, ticks -> line 0,0,1,0,1,0,1,0,1,0(parity),1; tx_done once; tx_active high exactly 11 bit periods.
REQ-033 PARITY=1, push 0xF0 -> data bits 0,0,0,0,1,1,1,1, parity bit 1, one stop bit 1.
REQ-034 DATA_W=7, STOP_BITS=2, PARITY=0, push 0x55 -> 0,1,0,1,0,1,0,1,1,1 (10 bits), then idle 1.
REQ-035 Push 0x11 then 0x22 back-to-back -> two frames, second start bit immediately after first stop bit, tx_done pulses twice, tx_active never drops between.
REQ-036 No ticks, 5 pushes, FIFO_DEPTH=4 -> fifo_level=4, tx_ready=0, overflow=1; 5th word never transmitted.
REQ-037 rst_n low during DATA bit 3 -> tx_data_out=1 and tx_active=0 same cycle; fifo_level=0; no tx_done.
